// File: rtl/prng_arbiter_if.sv
// Bundle of request/response and generator-control signals between the PRNG
// arbiter (slave) and its environment: requesters plus the LFSR generator (master).
interface prng_arbiter_if #(
  parameter int N    = 8,
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req_i;
  logic            seed_wr_i;
  logic [N-1:0]    seed_in_i;
  logic [N-1:0]    gen_value_i;
  logic            gen_step_o;
  logic            gen_load_o;
  logic [N-1:0]    gen_seed_o;
  logic [NREQ-1:0] gnt_o;
  logic            rnd_valid_o;
  logic [N-1:0]    rnd_data_o;
  logic            busy_o;

  modport slave (
    input  req_i, seed_wr_i, seed_in_i, gen_value_i,
    output gen_step_o, gen_load_o, gen_seed_o, gnt_o, rnd_valid_o, rnd_data_o, busy_o
  );

  modport master (
    output req_i, seed_wr_i, seed_in_i, gen_value_i,
    input  gen_step_o, gen_load_o, gen_seed_o, gnt_o, rnd_valid_o, rnd_data_o, busy_o
  );
endinterface

// File: rtl/prng_arbiter.sv
// Round-robin sharing of one LFSR generator: each grant steps the generator STEPS
// times before the word is delivered; seed writes are serviced between grants.
//
// state     | meaning
// S_IDLE    | waiting; seed load has priority over arbitration
// S_LOAD    | one-cycle seed-load strobe to the generator
// S_STEP    | generator shifting, STEPS cycles
// S_SETTLE  | one cycle for the generator output register to catch up
// S_DELIVER | gnt + rnd_valid for the latched requester
module prng_arbiter #(
  parameter int N     = 8,
  parameter int NREQ  = 4,
  parameter int STEPS = 8
) (
  input logic            clk,
  input logic            rst,
  prng_arbiter_if.slave  bus
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STEP,
    S_SETTLE,
    S_DELIVER
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   rr_q;
  logic [IW-1:0]   idx_q;
  logic [CW-1:0]   cnt_q;
  logic            pend_q;
  logic [N-1:0]    pend_seed_q;
  logic [N-1:0]    gen_seed_q;
  logic [N-1:0]    rnd_data_q;

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic [IW:0]       pick_sum;

  // An all-zero LFSR state never leaves zero, so zero seeds become one.
  function automatic logic [N-1:0] sanitize(input logic [N-1:0] s);
    return (s == '0) ? {{(N-1){1'b0}}, 1'b1} : s;
  endfunction

  // Rotate requests so bit 0 is the rr pointer; the lowest set offset wins.
  always_comb begin
    req_dbl    = {bus.req_i, bus.req_i};
    req_rot    = req_dbl[rr_q +: NREQ];
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_sum   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        pick_found = 1'b1;
        pick_sum   = {1'b0, rr_q} + (IW+1)'(i);
        if (pick_sum >= (IW+1)'(NREQ)) pick_sum = pick_sum - (IW+1)'(NREQ);
        pick_idx   = pick_sum[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_seed_q <= '0;
      gen_seed_q  <= {{(N-1){1'b0}}, 1'b1};
      rnd_data_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.seed_wr_i) begin
            gen_seed_q <= sanitize(bus.seed_in_i);
            state_q    <= S_LOAD;
          end else if (pend_q) begin
            gen_seed_q <= sanitize(pend_seed_q);
            state_q    <= S_LOAD;
          end else if (pick_found) begin
            idx_q   <= pick_idx;
            cnt_q   <= '0;
            state_q <= S_STEP;
          end
        end
        S_LOAD: begin
          pend_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_STEP: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(STEPS - 1)) state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          rnd_data_q <= bus.gen_value_i;
          state_q    <= S_DELIVER;
        end
        S_DELIVER: begin
          rr_q    <= (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // Placed after the case so a write landing in LOAD re-arms the flag.
      if (bus.seed_wr_i && state_q != S_IDLE) begin
        pend_q      <= 1'b1;
        pend_seed_q <= bus.seed_in_i;
      end
    end
  end

  assign bus.gen_step_o  = (state_q == S_STEP);
  assign bus.gen_load_o  = (state_q == S_LOAD);
  assign bus.gen_seed_o  = gen_seed_q;
  assign bus.rnd_valid_o = (state_q == S_DELIVER);
  assign bus.gnt_o       = (state_q == S_DELIVER) ? ({{(NREQ-1){1'b0}}, 1'b1} << idx_q) : '0;
  assign bus.rnd_data_o  = rnd_data_q;
  assign bus.busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_prng_arbiter.sv
// Directed and randomized checks of prng_arbiter against a transaction-level
// model: round-robin choice, STEPS generator shifts per word, and seed handling.
module tb_prng_arbiter;
  localparam int N     = 8;
  localparam int NREQ  = 4;
  localparam int STEPS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prng_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

  prng_arbiter #(.N(N), .NREQ(NREQ), .STEPS(STEPS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Generator model with its registered output
  logic [7:0] gen_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) gen_q <= 8'h01;
    else if (bus.gen_load_o) gen_q <= bus.gen_seed_o;
    else if (bus.gen_step_o) gen_q <= lfsr_next(gen_q);
  end
  assign bus.gen_value_i = gen_q;

  // Monitor: records deliveries and loads as observed at the falling edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_del = 0, n_ld = 0, steps_acc = 0, last_step_cyc = 0, bad_gnt = 0;
  logic [3:0] del_gnt [64];
  logic [7:0] del_data[64];
  int         del_cyc [64];
  int         del_steps[64];
  int         del_gap [64];
  logic [7:0] ld_seed [64];
  int         ld_cyc  [64];

  always @(negedge clk) begin
    if (rst) begin
      steps_acc = 0;
    end else begin
      if (bus.gen_step_o) begin
        steps_acc++;
        last_step_cyc = cyc;
      end
      if (bus.gen_load_o && n_ld < 64) begin
        ld_seed[n_ld] = bus.gen_seed_o;
        ld_cyc[n_ld]  = cyc;
        n_ld++;
      end
      if (bus.rnd_valid_o && n_del < 64) begin
        del_gnt[n_del]   = bus.gnt_o;
        del_data[n_del]  = bus.rnd_data_o;
        del_cyc[n_del]   = cyc;
        del_steps[n_del] = steps_acc;
        del_gap[n_del]   = cyc - last_step_cyc;
        steps_acc        = 0;
        n_del++;
      end
      if (((bus.gnt_o != '0) != bus.rnd_valid_o) || (bus.rnd_valid_o && !$onehot(bus.gnt_o)))
        bad_gnt++;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_del(input int target);
    int budget;
    budget = 0;
    while (n_del < target && budget < 200) begin
      tick();
      budget++;
    end
    check("wait_delivery", 32'(n_del >= target), 32'd1);
  endtask

  // Reference: spec-level arbitration and generator advance per delivered word
  logic [7:0] m_state;
  int         m_rr;

  function automatic int m_arb(input logic [3:0] r);
    for (int i = 0; i < NREQ; i++)
      if (r[(m_rr + i) % NREQ]) return (m_rr + i) % NREQ;
    return 0;
  endfunction

  task automatic check_delivery(input int d, input logic [3:0] r);
    int idx;
    idx = m_arb(r);
    for (int s = 0; s < STEPS; s++) m_state = lfsr_next(m_state);
    check("gnt", 32'(del_gnt[d]), 32'(4'b0001 << idx));
    check("rnd_data", 32'(del_data[d]), 32'(m_state));
    check("step_count", 32'(del_steps[d]), 32'(STEPS));
    check("settle_gap", 32'(del_gap[d]), 32'd2);
    m_rr = (idx + 1) % NREQ;
  endtask

  task automatic wait_step();
    int budget;
    budget = 0;
    while (!bus.gen_step_o && budget < 50) begin
      tick();
      budget++;
    end
    check("step_seen", 32'(bus.gen_step_o), 32'd1);
  endtask

  initial begin
    int         t0, nld, nd, d0;
    logic [7:0] s;
    logic [3:0] r;

    bus.req_i     = '0;
    bus.seed_wr_i = 1'b0;
    bus.seed_in_i = '0;
    m_state       = 8'h01;
    m_rr          = 0;

    // Reset values
    repeat (3) tick();
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_gnt", 32'(bus.gnt_o), 32'd0);
    check("rst_valid", 32'(bus.rnd_valid_o), 32'd0);
    check("rst_step", 32'(bus.gen_step_o), 32'd0);
    check("rst_load", 32'(bus.gen_load_o), 32'd0);
    check("rst_seed", 32'(bus.gen_seed_o), 32'h01);
    check("rst_data", 32'(bus.rnd_data_o), 32'h00);
    rst = 1'b0;
    tick();

    // Single pulsed request; delivery still completes
    t0 = cyc;
    bus.req_i = 4'b0100;
    tick();
    bus.req_i = '0;
    wait_del(1);
    check_delivery(0, 4'b0100);
    check("latency", 32'(del_cyc[0] - t0), 32'd10);
    tick();

    // All requesting: rotating order, fixed spacing
    bus.req_i = 4'b1111;
    for (int d = 1; d <= 5; d++) begin
      wait_del(d + 1);
      check_delivery(d, 4'b1111);
      if (d > 1) check("spacing", 32'(del_cyc[d] - del_cyc[d-1]), 32'(STEPS + 3));
    end
    bus.req_i = '0;
    tick();

    // Randomized requests with occasional seed writes from IDLE
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        s = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        bus.seed_wr_i = 1'b1;
        bus.seed_in_i = s;
        tick();
        m_state = (s == 8'h00) ? 8'h01 : s;
        check("rand_load", 32'(bus.gen_load_o), 32'd1);
        check("rand_seed", 32'(bus.gen_seed_o), 32'(m_state));
        bus.seed_wr_i = 1'b0;
        tick();
      end
      r  = 4'($urandom_range(1, 15));
      d0 = n_del;
      bus.req_i = r;
      wait_del(d0 + 1);
      check_delivery(d0, r);
      bus.req_i = '0;
      tick();
    end

    // Zero seed sanitized; seed write beats a simultaneous request
    bus.seed_wr_i = 1'b1;
    bus.seed_in_i = 8'h00;
    tick();
    check("zero_seed_load", 32'(bus.gen_load_o), 32'd1);
    check("zero_seed_val", 32'(bus.gen_seed_o), 32'h01);
    bus.seed_wr_i = 1'b0;
    m_state = 8'h01;
    tick();
    nld = n_ld;
    bus.seed_wr_i = 1'b1;
    bus.seed_in_i = 8'hA5;
    bus.req_i     = 4'b0001;
    tick();
    check("a5_load", 32'(bus.gen_load_o), 32'd1);
    check("a5_seed", 32'(bus.gen_seed_o), 32'hA5);
    check("a5_no_step_yet", 32'(steps_acc), 32'd0);
    bus.seed_wr_i = 1'b0;
    m_state = 8'hA5;
    d0 = n_del;
    wait_del(d0 + 1);
    check_delivery(d0, 4'b0001);
    check("a5_single_load", 32'(n_ld - nld), 32'd1);
    bus.req_i = '0;
    tick();

    // Two seed writes during STEP: latest wins, one load after delivery
    bus.req_i = 4'b0010;
    wait_step();
    nld = n_ld;
    d0  = n_del;
    bus.seed_wr_i = 1'b1;
    bus.seed_in_i = 8'h3C;
    tick();
    bus.seed_in_i = 8'h5A;
    tick();
    bus.seed_wr_i = 1'b0;
    wait_del(d0 + 1);
    check_delivery(d0, 4'b0010);
    m_state = 8'h5A;
    wait_del(d0 + 2);
    check_delivery(d0 + 1, 4'b0010);
    check("pend_load_count", 32'(n_ld - nld), 32'd1);
    check("pend_load_seed", 32'(ld_seed[n_ld-1]), 32'h5A);
    check("pend_after_del", 32'(ld_cyc[n_ld-1] > del_cyc[d0]), 32'd1);
    check("pend_before_gnt", 32'(ld_cyc[n_ld-1] < del_cyc[d0+1]), 32'd1);
    bus.req_i = '0;
    tick();

    // Reset in the 4th STEP cycle with a pending seed
    bus.req_i = 4'b1111;
    wait_step();
    bus.seed_wr_i = 1'b1;
    bus.seed_in_i = 8'h77;
    tick();
    bus.seed_wr_i = 1'b0;
    tick();
    tick();
    check("pre_rst_step", 32'(bus.gen_step_o), 32'd1);
    nd  = n_del;
    nld = n_ld;
    rst = 1'b1;
    #1;
    check("async_step", 32'(bus.gen_step_o), 32'd0);
    check("async_busy", 32'(bus.busy_o), 32'd0);
    check("async_valid", 32'(bus.rnd_valid_o), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    m_state = 8'h01;
    m_rr    = 0;
    check("no_abort_delivery", 32'(n_del - nd), 32'd0);
    wait_del(nd + 1);
    check_delivery(nd, 4'b1111);
    check("pend_discarded", 32'(n_ld - nld), 32'd0);
    bus.req_i = '0;
    tick();

    check("gnt_only_in_deliver", 32'(bad_gnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
